demux8_deser: RTL and testbench

- Receive-side counterpart of the 8:1 select mux. Takes a 1-bit serial stream and writes each bit into output slot k, where k steps 0..7 under an internal 3-bit select counter.
- Presents the assembled 8-bit word with a valid/ready handshake.
- Slot k maps to mux select value k (bit 0 = A … bit 7 = H). Feeding `dout` back into the 8:1 mux with sel=k returns bit k.

---
 rtl/demux8_deser_pkg.sv | 17 +
 rtl/demux8_deser_if.sv | 33 +++
 rtl/demux8_deser_dec38.sv | 20 ++
 rtl/demux8_deser.sv | 110 +++++++++++
 tb/tb_demux8_deser.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/demux8_deser_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mux8_pkg : shared types/constants for the 8:1 mux and its deserializer
// Rev 1.0
// ------------------------------------------------------------------
package mux8_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/demux8_deser_if.sv
`default_nettype none
// ------------------------------------------------------------------
// demux8_deser_if : serial input / word output bus of the deserializer
// Rev 1.0
// ------------------------------------------------------------------
interface demux8_deser_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) ();

  logic             din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [SEL_W-1:0] sel_idx;
  logic             busy;
  logic             overrun;
  logic             sync_err;

  modport slave (
    input  din, din_valid, sof, dout_ready,
    output dout, dout_valid, sel_idx, busy, overrun, sync_err
  );

  modport master (
    output din, din_valid, sof, dout_ready,
    input  dout, dout_valid, sel_idx, busy, overrun, sync_err
  );

endinterface
`default_nettype wire

// File: rtl/demux8_deser_dec38.sv
`default_nettype none
// ------------------------------------------------------------------
// dec38 : SEL_W-to-WIDTH one-hot decoder with enable
// Rev 1.0
// ------------------------------------------------------------------
module dec38 #(
  parameter int WIDTH = mux8_pkg::WIDTH,
  parameter int SEL_W = mux8_pkg::SEL_W
) (
  input  wire logic             en,
  input  wire logic [SEL_W-1:0] sel,
  output logic      [WIDTH-1:0] onehot
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    assign onehot[i] = en && (sel == SEL_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ------------------------------------------------------------------
// demux8_deser : 1:8 serial-to-parallel demux with valid/ready output
// Rev 1.0
// ------------------------------------------------------------------
module demux8_deser #(
  parameter int WIDTH = mux8_pkg::WIDTH,
  parameter int SEL_W = mux8_pkg::SEL_W
) (
  input  wire logic       clk,
  input  wire logic       rst,
  demux8_deser_if.slave   bus
);

  import mux8_pkg::*;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  logic [SEL_W-1:0] wr_idx;
  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] asm_base;
  logic [WIDTH-1:0] asm_wr;
  logic             slot_free;

  // sof always restarts at slot 0, otherwise the running index is used
  assign wr_idx = bus.sof ? '0 : sel_q;

  dec38 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_dec (
    .en     (bus.din_valid),
    .sel    (wr_idx),
    .onehot (we)
  );

  assign asm_base  = bus.sof ? '0 : asm_q;
  assign asm_wr    = (asm_base & ~we) | (we & {WIDTH{bus.din}});
  assign slot_free = ~dout_valid_q | bus.dout_ready;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    asm_d        = asm_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~bus.dout_ready;
    overrun_d    = 1'b0;
    sync_err_d   = 1'b0;

    if (bus.din_valid) begin
      if (bus.sof) begin
        sync_err_d = (state_q == COLLECT);
        asm_d      = asm_wr;
        sel_d      = SEL_W'(1);
        state_d    = COLLECT;
      end else if (state_q == IDLE) begin
        sync_err_d = 1'b1;
      end else begin
        asm_d = asm_wr;
        if (sel_q == SEL_W'(WIDTH - 1)) begin
          sel_d   = '0;
          state_d = IDLE;
          if (slot_free) begin
            dout_d       = asm_wr;
            dout_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sel_idx    = sel_q;
  assign bus.busy       = (state_q == COLLECT);
  assign bus.overrun    = overrun_q;
  assign bus.sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_demux8_deser : directed + random bench with a frame-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_demux8_deser;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux8_deser_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) ifc ();

  demux8_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // reference model: bits of the frame being assembled, plus output slot
  bit             frame[$];
  logic [WIDTH-1:0] exp_dout  = '0;
  logic             exp_valid = 1'b0;
  logic             exp_ovr   = 1'b0;
  logic             exp_sync  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_sync  = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic d, input logic s, input logic r);
    logic [WIDTH-1:0] word;
    bit load;
    load     = 1'b0;
    exp_ovr  = 1'b0;
    exp_sync = 1'b0;
    if (v) begin
      if (s) begin
        exp_sync = (frame.size() != 0);
        frame.delete();
        frame.push_back(d);
      end else if (frame.size() == 0) begin
        exp_sync = 1'b1;
      end else begin
        frame.push_back(d);
        if (frame.size() == WIDTH) begin
          word = '0;
          foreach (frame[k]) word[k] = frame[k];
          if (!exp_valid || r) begin
            exp_dout = word;
            load     = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
          frame.delete();
        end
      end
    end
    if (load) exp_valid = 1'b1;
    else if (r) exp_valid = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":dout"},       32'(ifc.dout),       32'(exp_dout));
    chk({ctx, ":dout_valid"}, 32'(ifc.dout_valid), 32'(exp_valid));
    chk({ctx, ":sel_idx"},    32'(ifc.sel_idx),    32'(frame.size()));
    chk({ctx, ":busy"},       32'(ifc.busy),       32'(frame.size() != 0));
    chk({ctx, ":overrun"},    32'(ifc.overrun),    32'(exp_ovr));
    chk({ctx, ":sync_err"},   32'(ifc.sync_err),   32'(exp_sync));
  endtask

  task automatic step(input string ctx, input logic v, input logic d, input logic s, input logic r);
    @(negedge clk);
    ifc.din_valid  = v;
    ifc.din        = d;
    ifc.sof        = s;
    ifc.dout_ready = r;
    model_update(v, d, s, r);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic send_frame(input string ctx, input logic [WIDTH-1:0] w, input logic r);
    for (int k = 0; k < WIDTH; k++) step(ctx, 1'b1, w[k], k == 0, r);
  endtask

  function automatic logic mux81(input logic [WIDTH-1:0] w, input logic [SEL_W-1:0] sel);
    case (sel)
      3'd0: return w[0];
      3'd1: return w[1];
      3'd2: return w[2];
      3'd3: return w[3];
      3'd4: return w[4];
      3'd5: return w[5];
      3'd6: return w[6];
      default: return w[7];
    endcase
  endfunction

  initial begin
    logic [WIDTH-1:0] w;
    ifc.din = 1'b0; ifc.din_valid = 1'b0; ifc.sof = 1'b0; ifc.dout_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset");

    // basic frame, bits 1,0,1,1,0,0,1,0
    send_frame("basic", 8'h4D, 1'b1);
    chk("basic_word", 32'(ifc.dout), 32'h4D);
    chk("basic_valid", 32'(ifc.dout_valid), 32'h1);
    step("basic_drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // same frame with a 3-cycle gap between bits 3 and 4
    w = 8'h4D;
    for (int k = 0; k < 3; k++) step("gap", 1'b1, w[k], k == 0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step("gap_hold", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("gap_sel", 32'(ifc.sel_idx), 32'd3);
    end
    for (int k = 3; k < WIDTH; k++) step("gap", 1'b1, w[k], 1'b0, 1'b1);
    chk("gap_word", 32'(ifc.dout), 32'h4D);

    // backpressure and overrun
    send_frame("bp1", 8'h4D, 1'b0);
    send_frame("bp2", 8'hA5, 1'b0);
    chk("bp_ovr_pulse", 32'(ifc.overrun), 32'h1);
    chk("bp_word_kept", 32'(ifc.dout), 32'h4D);
    step("bp_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr_once", 32'(ifc.overrun), 32'h0);
    step("bp_release", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_cleared", 32'(ifc.dout_valid), 32'h0);

    // framing errors
    step("idle_nosof", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_sync", 32'(ifc.sync_err), 32'h1);
    chk("idle_sel0", 32'(ifc.sel_idx), 32'h0);
    for (int k = 0; k < 5; k++) step("resync_pre", 1'b1, 1'b0, k == 0, 1'b1);
    chk("resync_at5", 32'(ifc.sel_idx), 32'd5);
    step("resync_sof", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("resync_sync", 32'(ifc.sync_err), 32'h1);
    chk("resync_sel1", 32'(ifc.sel_idx), 32'h1);
    w = 8'h55;
    for (int k = 1; k < WIDTH; k++) step("resync_post", 1'b1, w[k], 1'b0, 1'b1);
    chk("resync_word", 32'(ifc.dout), 32'h55);

    // round trip through a bench-side 8:1 mux for every byte value
    for (int v = 0; v < 256; v++) begin
      w = 8'(v);
      send_frame("rt", w, 1'b1);
      for (int k = 0; k < WIDTH; k++)
        chk("rt_mux", 32'(mux81(ifc.dout, SEL_W'(k))), 32'(w[k]));
    end

    // random traffic
    for (int n = 0; n < 600; n++)
      step("rand", $urandom_range(0, 3) != 0, 1'($urandom), ($urandom % 9) == 0, 1'($urandom));

    // async reset mid-frame with a pending word
    send_frame("pre_rst", 8'hC3, 1'b0);
    for (int k = 0; k < 3; k++) step("pre_rst_part", 1'b1, 1'b1, k == 0, 1'b0);
    #2;
    rst = 1'b1;
    ifc.din_valid = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("post_rst", 8'h3C, 1'b1);
    chk("post_rst_word", 32'(ifc.dout), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
